// File: rtl/ifetch_queue_pkg.sv
// Shared CPU types and constants for the fetch front end and decode.
package ifetch_queue_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fifo_sync.sv
// Generic synchronous FIFO with flush; pop data is the registered head, visible the cycle after push.
// Backpressure: pop only on pop_vld && pop_rdy; the writer must respect count (no overflow guard).
module fifo_sync #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push_vld,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop_rdy,
   output logic                     pop_vld,
   output logic [WIDTH-1:0]         pop_dat,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   assign pop_vld = (count != '0);
   assign do_pop  = pop_vld && pop_rdy;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_vld && !flush)
         mem[wr_ptr] <= push_dat;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({push_vld, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Sequential instruction fetch with credit-limited requests, in-order response queue and redirect flush.
// Decode sees a response the cycle after it returns; requests stall when inflight + queued reaches DEPTH.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_C = {1'b0, DEPTH_N};

   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] rpc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop;
   logic [CW-1:0]   count;
   logic [CW:0]     credit_used;
   logic            req_fire;
   logic            resp_keep;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   // Queue space is reserved at request time, so the queue can never overflow.
   assign credit_used    = {1'b0, inflight} + {1'b0, count};
   assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_C);
   assign imem_req_addr  = fpc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign resp_keep      = imem_resp_valid && (drop == '0) && !redirect_valid;

   assign push_entry = '{pc: rpc, instr: imem_resp_data};
   assign dec_pc     = head.pc;
   assign dec_instr  = head.instr;

   fifo_sync #(
      .WIDTH($bits(fetch_entry_t)),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .push_vld (resp_keep),
      .push_dat (push_entry),
      .pop_rdy  (dec_ready),
      .pop_vld  (dec_valid),
      .pop_dat  (head),
      .count    (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc      <= RESET_PC;
         rpc      <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         case ({req_fire, imem_resp_valid})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: ;
         endcase
         if (redirect_valid) begin
            // A response landing this cycle is already discarded, so it is not owed a drop.
            fpc  <= align_pc(redirect_pc);
            rpc  <= align_pc(redirect_pc);
            drop <= imem_resp_valid ? inflight - 1'b1 : inflight;
         end else begin
            if (req_fire)
               fpc <= fpc + XLEN'(INSTR_BYTES);
            if (imem_resp_valid) begin
               if (drop != '0) drop <= drop - 1'b1;
               else            rpc  <= rpc + XLEN'(INSTR_BYTES);
            end
         end
      end
   end

   a_inflight_max: assert property (@(posedge clk) disable iff (rst) inflight <= DEPTH_N);
   a_drop_le_inflight: assert property (@(posedge clk) disable iff (rst) drop <= inflight);
   a_credit_max: assert property (@(posedge clk) disable iff (rst) credit_used <= DEPTH_C);

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of decode in the pipelined CPU.
- Generates sequential fetch addresses and issues them to an instruction memory with a valid/ready request port and an in-order response port of variable latency.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and presents them to decode through a valid/ready handshake.
- Accepts a redirect (branch/jump target) from execute, which flushes all queued and in-flight fetches.

Parameters:
DEPTH, 4, queue entries and max outstanding requests; power of 2, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_resp_valid  input  1  response valid; responses in request order, at least 1 cycle after acceptance
imem_resp_data  input  32  fetched instruction
dec_valid  output  1  queue head valid to decode
dec_ready  input  1  decode consumes head
dec_pc  output  32  PC of head instruction
dec_instr  output  32  head instruction
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  32  new fetch PC; bits [1:0] ignored, treated as 00

Behaviour:
- State:
  - fpc: next request address.
  - rpc: PC of next expected response.
  - inflight: accepted requests not yet responded, 0..DEPTH.
  - drop: responses still to discard, 0..DEPTH.
  - queue: count 0..DEPTH.
- Reset (async, any time, including mid-transfer):
  - fpc = rpc = RESET_PC.
  - inflight = drop = count = 0.
  - dec_valid = 0.
  - imem_req_valid = 0 while rst is high.
  - Memory responses still in flight at reset are the memory's responsibility, not this block's.
- Request:
  - imem_req_valid = !rst && !redirect_valid && (inflight + count < DEPTH). This credit rule guarantees the queue never overflows.
  - imem_req_addr = fpc.
  - On valid && ready: fpc += 4 (wraps modulo 2^32), inflight += 1.
  - Once asserted, imem_req_valid and imem_req_addr are held until accepted, unless a redirect occurs.
- Response:
  - On imem_resp_valid: inflight -= 1.
  - If drop > 0: discard the response, drop -= 1.
  - Otherwise: enqueue {rpc, imem_resp_data}, rpc += 4.
- Decode side:
  - dec_valid = count != 0; dec_pc and dec_instr come from the head entry.
  - Dequeue on dec_valid && dec_ready.
  - No bypass: a response is visible on dec_valid the cycle after it is returned.
  - Head outputs are stable while dec_valid && !dec_ready.
- Simultaneous enqueue and dequeue: count unchanged. This is legal at count == DEPTH only if the credit rule allowed it (it cannot occur).
- Redirect (registered, takes effect at the clock edge):
  - fpc = rpc = redirect_pc & ~3; count = 0.
  - drop = inflight after this cycle's accounting: any response arriving in the redirect cycle is itself discarded and not counted, and no request is accepted that cycle.
  - Any dequeue in the redirect cycle is still a valid handshake, but the queue is emptied regardless.
  - dec_valid = 0 the cycle after a redirect.
  - New requests may issue the cycle after a redirect while drops are outstanding. Those requests count in inflight, and in-order responses keep the accounting correct.
- Back-to-back redirects: the last one wins; drop is recomputed each time.
- Assertions:
  - inflight <= DEPTH.
  - drop <= inflight.
  - inflight + count <= DEPTH.

Decomposition:
- Shared CPU package holds:
  - XLEN = 32.
  - INSTR_BYTES = 4.
  - NOP_INSTR = 32'h0000_0013, which decode substitutes when dec_valid is low.
- One natural sub-module: fifo_sync, a parameterised width/depth synchronous FIFO with async reset and a flush input. It is instantiated with width 64 for {pc, instr}.
- ifetch_queue keeps the PC, credit and drop counters.

Test Plan:
1. Reset release, memory always ready, 1-cycle latency, dec_ready = 1:
   - Requests go to 0x0, 0x4, 0x8.
   - Decode sees pc 0x0, 0x4, 0x8 in order, one per cycle in steady state.
2. Hold dec_ready = 0, DEPTH = 4:
   - Exactly 4 requests are accepted, then imem_req_valid drops.
   - count = 4.
   - Releasing dec_ready restores one request per dequeue.
3. Memory latency 3 cycles, 3 requests in flight, redirect to 0x100:
   - The 3 old responses are discarded.
   - The first decoded pc is 0x100 with the instruction returned for address 0x100.
4. Redirect in the same cycle as a response and a dequeue:
   - The response is dropped and the queue empties.
   - dec_valid = 0 on the next cycle.
   - The next fetch address is the redirect target.
5. redirect_pc = 0x203:
   - imem_req_addr = 0x200 and dec_pc = 0x200.
6. Assert rst mid-stream with a full queue:
   - dec_valid and imem_req_valid go low immediately (asynchronously).
   - After release, fetching restarts at RESET_PC.
